// File: rtl/digit_scan_loader.sv
// Multi-digit display scanner: one character code per digit, time-multiplexed
// onto a shared character bus with active-low anodes. Each slot is split into
// pre-blank, on and post-blank phases so the bus only changes while all anodes
// are dark. New data is double-buffered and swapped in at the frame boundary.
module digit_scan_loader #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CHAR_W     = 3,
  parameter int unsigned PRE_BLANK  = 2,
  parameter int unsigned ON_CYCLES  = 1,
  parameter int unsigned POST_BLANK = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic [NUM_DIGITS*CHAR_W-1:0]   data_in,
  input  logic                           enable,
  input  logic [NUM_DIGITS-1:0]          blank_mask,
  output logic [NUM_DIGITS-1:0]          an,
  output logic [CHAR_W-1:0]              char,
  output logic [$clog2(NUM_DIGITS)-1:0]  digit_idx,
  output logic                           frame_done,
  output logic                           pending
);

  localparam int unsigned Slot = PRE_BLANK + ON_CYCLES + POST_BLANK;
  localparam int unsigned KW   = $clog2(Slot);
  localparam int unsigned IW   = $clog2(NUM_DIGITS);
  localparam int unsigned DW   = NUM_DIGITS * CHAR_W;

  localparam logic [KW-1:0] KLast    = KW'(Slot - 1);
  localparam logic [KW-1:0] KPreLast = KW'(PRE_BLANK - 1);
  localparam logic [KW-1:0] KOnLast  = KW'(PRE_BLANK + ON_CYCLES - 1);
  localparam logic [IW-1:0] ILast    = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StPre, StOn, StPost} phase_e;

  // State registers describe the current cycle; outputs are registered from
  // the next-state values so they line up with the counters.
  phase_e          phase_q, phase_d;
  logic [KW-1:0]   k_q, k_d;
  logic [IW-1:0]   i_q, i_d;
  logic [DW-1:0]   active_q, active_d;
  logic [DW-1:0]   pend_data_q, pend_data_d;
  logic            pending_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic [CHAR_W-1:0]     char_d;
  logic            frame_done_d;
  logic            frame_end;

  // Next-state: slot/digit counters, phase sequencing, load buffering, outputs.
  always_comb begin
    k_d         = k_q + 1'b1;
    i_d         = i_q;
    phase_d     = phase_q;
    active_d    = active_q;
    pend_data_d = pend_data_q;
    pending_d   = pending;
    an_d        = '1;

    frame_end = (i_q == ILast) && (k_q == KLast);

    if (k_q == KLast) begin
      k_d = '0;
      i_d = (i_q == ILast) ? '0 : i_q + 1'b1;
    end

    unique case (phase_q)
      StPre:   if (k_q == KPreLast) phase_d = StOn;
      StOn:    if (k_q == KOnLast) phase_d = (POST_BLANK == 0) ? StPre : StPost;
      StPost:  if (k_q == KLast) phase_d = StPre;
      default: phase_d = StPre;
    endcase

    if (load) pend_data_d = data_in;

    // A load in the boundary cycle bypasses the buffer and goes live directly.
    if (frame_end) begin
      if (load) begin
        active_d = data_in;
      end else if (pending) begin
        active_d = pend_data_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end

    if (phase_d == StOn && enable && !blank_mask[i_d]) an_d[i_d] = 1'b0;

    char_d       = active_d[i_d*CHAR_W +: CHAR_W];
    frame_done_d = (i_d == ILast) && (k_d == KLast);
  end

  // State and registered outputs; reset blanks the display immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q     <= StPre;
      k_q         <= '0;
      i_q         <= '0;
      active_q    <= '0;
      pend_data_q <= '0;
      pending     <= 1'b0;
      an          <= '1;
      char        <= '0;
      frame_done  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      k_q         <= k_d;
      i_q         <= i_d;
      active_q    <= active_d;
      pend_data_q <= pend_data_d;
      pending     <= pending_d;
      an          <= an_d;
      char        <= char_d;
      frame_done  <= frame_done_d;
    end
  end

  assign digit_idx = i_q;

endmodule

// File: tb/tb_digit_scan_loader.sv
// Directed bench for digit_scan_loader: default 4-digit instance plus a
// 2-digit variant (PRE=1, ON=2, POST=0) sharing clock and reset.
module tb_digit_scan_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [11:0] data_in = '0;
  logic        enable = 1'b1;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  an;
  logic [2:0]  char;
  logic [1:0]  digit_idx;
  logic        frame_done;
  logic        pending;

  logic        load2 = 1'b0;
  logic [5:0]  data_in2 = '0;
  logic        enable2 = 1'b1;
  logic [1:0]  blank_mask2 = '0;
  logic [1:0]  an2;
  logic [2:0]  char2;
  logic [0:0]  digit_idx2;
  logic        frame_done2;
  logic        pending2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  digit_scan_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .enable     (enable),
    .blank_mask (blank_mask),
    .an         (an),
    .char       (char),
    .digit_idx  (digit_idx),
    .frame_done (frame_done),
    .pending    (pending)
  );

  digit_scan_loader #(
    .NUM_DIGITS (2),
    .CHAR_W     (3),
    .PRE_BLANK  (1),
    .ON_CYCLES  (2),
    .POST_BLANK (0)
  ) dut2 (
    .clk        (clk),
    .reset      (reset),
    .load       (load2),
    .data_in    (data_in2),
    .enable     (enable2),
    .blank_mask (blank_mask2),
    .an         (an2),
    .char       (char2),
    .digit_idx  (digit_idx2),
    .frame_done (frame_done2),
    .pending    (pending2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Digit (c/4)%4 lights at slot cycle 2 unless masked or disabled.
  function automatic logic [3:0] exp_an(input int c, input logic [3:0] mask, input bit en_ok);
    int d;
    d = (c / 4) % 4;
    if ((c % 4) == 2 && en_ok && !mask[d]) return ~(4'b0001 << d);
    return 4'hF;
  endfunction

  // Character expected after 12'h8D1 goes live at cycle 16.
  function automatic logic [2:0] exp_char_new(input int c);
    if (c < 16) return 3'd0;
    return 3'(((c - 16) / 4) + 1);
  endfunction

  // Leaves the bench in cycle 0 (just after a negedge, before the first edge).
  task automatic do_reset();
    reset      = 1'b0;
    load       = 1'b0;
    data_in    = '0;
    enable     = 1'b1;
    blank_mask = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Scenario 1 + variant: idle scan.
    do_reset();
    for (int c = 0; c < 32; c++) begin
      check_eq($sformatf("s1 an c=%0d", c), 32'(an), 32'(exp_an(c, 4'b0000, 1'b1)));
      check_eq($sformatf("s1 char c=%0d", c), 32'(char), 32'd0);
      check_eq($sformatf("s1 idx c=%0d", c), 32'(digit_idx), 32'((c / 4) % 4));
      check_eq($sformatf("s1 fd c=%0d", c), 32'(frame_done), 32'((c % 16) == 15));
      check_eq($sformatf("s1 pend c=%0d", c), 32'(pending), 32'd0);
      if (c < 12) begin
        check_eq($sformatf("s6 an c=%0d", c), 32'(an2),
                 32'(((c % 3) != 0) ? (((c / 3) % 2 == 0) ? 2'b10 : 2'b01) : 2'b11));
        check_eq($sformatf("s6 fd c=%0d", c), 32'(frame_done2), 32'((c % 6) == 5));
        check_eq($sformatf("s6 idx c=%0d", c), 32'(digit_idx2), 32'((c / 3) % 2));
      end
      @(negedge clk);
    end

    // Scenario 2: buffered load mid-frame.
    do_reset();
    data_in = 12'h8D1;
    for (int c = 0; c < 32; c++) begin
      load = (c == 5);
      check_eq($sformatf("s2 pend c=%0d", c), 32'(pending), 32'(c >= 6 && c <= 15));
      check_eq($sformatf("s2 char c=%0d", c), 32'(char), 32'(exp_char_new(c)));
      check_eq($sformatf("s2 an c=%0d", c), 32'(an), 32'(exp_an(c, 4'b0000, 1'b1)));
      @(negedge clk);
    end
    load = 1'b0;

    // Scenario 3a: load in the boundary cycle goes straight to active.
    do_reset();
    data_in = 12'h8D1;
    for (int c = 0; c < 20; c++) begin
      load = (c == 15);
      check_eq($sformatf("s3a pend c=%0d", c), 32'(pending), 32'd0);
      check_eq($sformatf("s3a char c=%0d", c), 32'(char), 32'(exp_char_new(c)));
      @(negedge clk);
    end
    load = 1'b0;

    // Scenario 3b: two loads in one frame, last wins.
    do_reset();
    for (int c = 0; c < 32; c++) begin
      load    = (c == 3) || (c == 9);
      data_in = (c == 3) ? 12'h111 : 12'h8D1;
      check_eq($sformatf("s3b pend c=%0d", c), 32'(pending), 32'(c >= 4 && c <= 15));
      check_eq($sformatf("s3b char c=%0d", c), 32'(char), 32'(exp_char_new(c)));
      @(negedge clk);
    end
    load = 1'b0;

    // Scenario 4: digit 1 masked, then a disabled frame.
    do_reset();
    blank_mask = 4'b0010;
    for (int c = 0; c < 48; c++) begin
      enable = !(c >= 16 && c <= 31);
      // Output at cycle c reflects enable sampled during cycle c-1.
      check_eq($sformatf("s4 an c=%0d", c), 32'(an),
               32'(exp_an(c, 4'b0010, !(c >= 17 && c <= 32))));
      check_eq($sformatf("s4 fd c=%0d", c), 32'(frame_done), 32'((c % 16) == 15));
      @(negedge clk);
    end
    enable     = 1'b1;
    blank_mask = '0;

    // Scenario 5: asynchronous reset while digit 3 is lit.
    do_reset();
    data_in = 12'h8D1;
    for (int c = 0; c < 14; c++) begin
      load = (c == 5);
      @(negedge clk);
    end
    load = 1'b0;
    check_eq("s5 an before reset", 32'(an), 32'h7);
    check_eq("s5 pend before reset", 32'(pending), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("s5 async an", 32'(an), 32'hF);
    check_eq("s5 async char", 32'(char), 32'd0);
    check_eq("s5 async pend", 32'(pending), 32'd0);
    check_eq("s5 async idx", 32'(digit_idx), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check_eq($sformatf("s5 an c=%0d", c), 32'(an), 32'(exp_an(c, 4'b0000, 1'b1)));
      check_eq($sformatf("s5 char c=%0d", c), 32'(char), 32'd0);
      check_eq($sformatf("s5 pend c=%0d", c), 32'(pending), 32'd0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_scan_loader.md
Name: digit_scan_loader

Overview:
- Parametrised multi-digit display scanner for the UART receive path.
- Holds one character code per digit and time-multiplexes them onto a shared character bus with active-low per-digit anode enables.
- Each digit is driven in a slot with configurable blanking before and after its on-time, so the character bus never changes while an anode is lit.
- New display data is double-buffered and applied only at a frame boundary (tear-free), with per-digit blanking and a global enable.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=2)
- CHAR_W, 3, width of one character code
- PRE_BLANK, 2, blank cycles at slot start during which char is already valid (>=1)
- ON_CYCLES, 1, cycles the digit's anode is low (>=1)
- POST_BLANK, 1, blank cycles at slot end (>=0)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- load  in  1  one-cycle strobe: capture data_in
- data_in  in  NUM_DIGITS*CHAR_W  character codes; field i = bits [i*CHAR_W +: CHAR_W] belongs to digit i
- enable  in  1  1 = anodes may light; 0 = all anodes off, scan timing continues
- blank_mask  in  NUM_DIGITS  bit i = 1 forces digit i's anode off
- an  out  NUM_DIGITS  active-low anode enables, registered
- char  out  CHAR_W  character code of the digit in the current slot, registered
- digit_idx  out  clog2(NUM_DIGITS)  index of the current slot
- frame_done  out  1  one-cycle pulse on the last cycle of the last slot
- pending  out  1  1 while captured data awaits the frame boundary

Behaviour:
- SLOT = PRE_BLANK+ON_CYCLES+POST_BLANK; FRAME = NUM_DIGITS*SLOT cycles.
- Internal state:
  - slot cycle counter k (0..SLOT-1) and digit index i (0..NUM_DIGITS-1).
  - k wraps to 0 and increments i at end of slot.
  - i wraps from NUM_DIGITS-1 to 0. Scan order is ascending from digit 0.
- Phase FSM per slot: PRE (k<PRE_BLANK) -> ON (next ON_CYCLES cycles) -> POST (remaining); POST skipped when POST_BLANK=0.
- Outputs during slot i, cycle k:
  - char = active field i for the whole slot.
  - an[i] = 0 only in ON phase and when enable=1 and blank_mask[i]=0. All other anode bits are 1.
  - enable and blank_mask are sampled each cycle; a change affects the next registered output.
- frame_done = 1 exactly when i=NUM_DIGITS-1 and k=SLOT-1.
- Load buffering:
  - load=1 captures data_in into the pending register and sets pending=1 on the next edge.
  - Multiple loads within one frame: the last one wins.
  - At the boundary edge (the cycle where frame_done=1): if pending=1, active <= pending register and pending clears.
  - If load=1 in the frame_done cycle itself, data_in is written directly to active and pending stays/clears to 0.
  - The new data is visible from slot 0 of the next frame.
- Reset (asynchronous, takes effect immediately, including mid-ON):
  - an = all 1, char = 0, digit_idx = 0, frame_done = 0, pending = 0.
  - Active and pending registers = 0; k = 0.
- First edge after reset release is cycle 0 of slot 0, so char = active field 0 = 0 with anodes off.

Test Plan (defaults NUM_DIGITS=4, CHAR_W=3, PRE=2, ON=1, POST=1; SLOT=4, FRAME=16; cycle 0 = first cycle after reset release; enable=1, blank_mask=0):
1. Idle scan, no load -> an=4'b1110 at cycle 2 only, 4'b1101 at 6, 4'b1011 at 10, 4'b0111 at 14, 4'b1111 elsewhere; frame_done at 15, 31, ...; char=0 throughout; digit_idx steps 0,1,2,3 every 4 cycles.
2. load with data_in=12'h8D1 (fields 1,2,3,4) at cycle 5:
   - pending=1 from cycle 6 through cycle 15.
   - char stays 0 up to cycle 15.
   - Cycles 16-19 char=1, 20-23 char=2, 24-27 char=3, 28-31 char=4.
   - Anodes never low while char changes.
3. load data_in=12'h8D1 exactly at cycle 15 -> pending never asserts; char=1 at cycle 16. Loads at cycles 3 (12'h111) and 9 (12'h8D1) -> next frame shows 1,2,3,4.
4. Digit masking: blank_mask=4'b0010 -> an[1] never 0 while the other digits pulse as in scenario 1. Then enable=0 for cycles 16-31 -> an=4'b1111 for that whole frame, frame_done still at 31, scanning resumes at 34.
5. Reset asserted at cycle 14 (an=4'b0111 active):
   - an=4'b1111, char=0, pending=0 immediately, without waiting for a clock edge.
   - After release, scenario 1 timing restarts from cycle 0 and previously loaded data is gone.
6. Parameter variant NUM_DIGITS=2, PRE=1, ON=2, POST=0 -> SLOT=3; an=2'b10 at cycles 1-2, 2'b01 at 4-5; frame_done at 5, 11.
